// File: rtl/scalar_pipe_pkg.sv
// scalar_pipe_pkg: shared widths and execute payload type for the scalar operand stage
//   OP_WIDTH / REG_SIZE / REG_QTY / SEL_WIDTH : default field widths
//   exPayload_t : operands, destination, write enable and opcode handed to execute
package scalar_pipe_pkg;
    localparam int OP_WIDTH  = 4;
    localparam int REG_SIZE  = 8;
    localparam int REG_QTY   = 8;
    localparam int SEL_WIDTH = $clog2(REG_QTY);
    typedef struct packed {
        logic [REG_SIZE-1:0]  a;
        logic [REG_SIZE-1:0]  b;
        logic [SEL_WIDTH-1:0] rd;
        logic                 wrEn;
        logic [OP_WIDTH-1:0]  op;
    } exPayload_t;
endpackage

// File: rtl/scalar_scoreboard.sv
// scalar_scoreboard: per-register pending-write bits and RAW/WAW hazard detection
//   clk, reset (sync, active-low)
//   rs1, rs2, rd, wrEn : sources/destination of the instruction being decoded
//   setEn              : instruction accepted and writes rd
//   wbValid, wbRd      : write-back clearing a pending bit
//   flushClr, flushRd  : killed payload releasing its destination
//   hazard             : instruction must stall
module scalar_scoreboard #(
    parameter int registerQuantity = 8,
    parameter int selWidth         = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [selWidth-1:0] rs1,
    input  logic [selWidth-1:0] rs2,
    input  logic [selWidth-1:0] rd,
    input  logic                wrEn,
    input  logic                setEn,
    input  logic                wbValid,
    input  logic [selWidth-1:0] wbRd,
    input  logic                flushClr,
    input  logic [selWidth-1:0] flushRd,
    output logic                hazard
);
    logic [registerQuantity-1:0] pending, clrMask, setMask;
    // A write-back to the same register clears it this edge and is forwarded, so it does not stall
    assign hazard = (pending[rs1] && !(wbValid && wbRd == rs1))
                 || (pending[rs2] && !(wbValid && wbRd == rs2))
                 || (wrEn && pending[rd] && !(wbValid && wbRd == rd));
    assign clrMask = (registerQuantity'(wbValid) << wbRd) | (registerQuantity'(flushClr) << flushRd);
    assign setMask = registerQuantity'(setEn) << rd;
    // Set is applied after clear so a same-cycle set of the cleared index wins
    always_ff @(posedge clk)
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clrMask) | setMask;
endmodule

// File: rtl/scalar_operand_stage.sv
// scalar_operand_stage: register read, hazard stall, write-back forwarding and execute pipeline register
//   clk, reset (sync, active-low)
//   idValid/idReady, idRs1, idRs2, idRd, idWrEn, idOp : decoded instruction handshake
//   rSel1, rSel2, reg1In, reg2In                      : register-file read port
//   wbValid, wbRd, wbData                             : write-back bus
//   flush                                             : kill held payload
//   exValid/exReady, exA, exB, exRd, exWrEn, exOp     : execute payload handshake
import scalar_pipe_pkg::*;
module scalar_operand_stage #(
    parameter int registerSize     = REG_SIZE,
    parameter int registerQuantity = REG_QTY,
    parameter int selWidth         = SEL_WIDTH,
    parameter int opWidth          = OP_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    idValid,
    output logic                    idReady,
    input  logic [selWidth-1:0]     idRs1,
    input  logic [selWidth-1:0]     idRs2,
    input  logic [selWidth-1:0]     idRd,
    input  logic                    idWrEn,
    input  logic [opWidth-1:0]      idOp,
    output logic [selWidth-1:0]     rSel1,
    output logic [selWidth-1:0]     rSel2,
    input  logic [registerSize-1:0] reg1In,
    input  logic [registerSize-1:0] reg2In,
    input  logic                    wbValid,
    input  logic [selWidth-1:0]     wbRd,
    input  logic [registerSize-1:0] wbData,
    input  logic                    flush,
    output logic                    exValid,
    input  logic                    exReady,
    output logic [registerSize-1:0] exA,
    output logic [registerSize-1:0] exB,
    output logic [selWidth-1:0]     exRd,
    output logic                    exWrEn,
    output logic [opWidth-1:0]      exOp
);
    exPayload_t payload;
    logic hazard, accept;
    logic [registerSize-1:0] fwdA, fwdB;
    assign rSel1   = idRs1;
    assign rSel2   = idRs2;
    assign fwdA    = (wbValid && wbRd == idRs1) ? wbData : reg1In;
    assign fwdB    = (wbValid && wbRd == idRs2) ? wbData : reg2In;
    assign idReady = reset && !flush && !hazard && (!exValid || exReady);
    assign accept  = idValid && idReady;
    scalar_scoreboard #(.registerQuantity(registerQuantity), .selWidth(selWidth)) sb (
        .clk(clk), .reset(reset), .rs1(idRs1), .rs2(idRs2), .rd(idRd), .wrEn(idWrEn),
        .setEn(accept && idWrEn), .wbValid(wbValid), .wbRd(wbRd),
        .flushClr(flush && exValid && payload.wrEn), .flushRd(payload.rd), .hazard(hazard)
    );
    // Payload fields hold after a transfer; only exValid drops
    always_ff @(posedge clk)
        if (!reset) begin
            payload <= '0;
            exValid <= 1'b0;
        end else if (flush) exValid <= 1'b0;
        else if (accept) begin
            payload <= '{a: fwdA, b: fwdB, rd: idRd, wrEn: idWrEn, op: idOp};
            exValid <= 1'b1;
        end else if (exReady) exValid <= 1'b0;
    assign exA    = payload.a;
    assign exB    = payload.b;
    assign exRd   = payload.rd;
    assign exWrEn = payload.wrEn;
    assign exOp   = payload.op;
endmodule
